poc_arbiter: RTL and testbench
==============================

POC_ARBITER -- requirements
Module: poc_arbiter

Interface
REQ-001 SHALL take parameter POLL_GAP, default 4: idle cycles between status-register polls in polling mode.
REQ-002 SHALL take parameter TIMEOUT, default 1023: maximum cycles spent waiting for POC ready before a transfer is aborted.
REQ-003 i_clk  in  1  sole clock; all logic updates on rising edge.
REQ-004 i_rst  in  1  reset, synchronous, active-high.
REQ-005 i_mode  in  1  0 = polling, 1 = interrupt.
REQ-006 i_req_valid  in  4  per-requester byte-pending flag.
REQ-007 i_req_data  in  32  packed bytes; requester k occupies bits [8k+7:8k].
REQ-008 o_req_ready  out  4  one-hot, one-cycle pulse; byte of requester k captured.
REQ-009 o_cs  out  1  one-cycle POC bus strobe.
REQ-010 o_rw  out  1  1 = read, 0 = write; valid with o_cs.
REQ-011 o_addr  out  1  0 = status register SR, 1 = buffer register BR; valid with o_cs.
REQ-012 o_wdata  out  8  write data; valid with o_cs and o_rw=0.
REQ-013 i_rdata  in  8  POC read data; valid the cycle after a read strobe.
REQ-014 i_irq_n  in  1  POC interrupt, active-low level.
REQ-015 o_gnt  out  4  one-hot owner of the transfer in progress; 0 when idle.
REQ-016 o_busy  out  1  high in every state except IDLE.
REQ-017 o_err  out  1  one-cycle pulse on timeout abort.
REQ-018 o_cnt  out  16  count of bytes delivered to BR; wraps 0xFFFF -> 0x0000.

Function
REQ-019 SHALL implement states IDLE, RD_SR, CHK_SR, GAP, EN_IRQ, WAIT_IRQ, WR_BR, WR_SR.
REQ-020 In IDLE with any i_req_valid bit set, SHALL grant round-robin starting at pointer ptr, searching ptr, ptr+1, ... mod 4.
REQ-021 SHALL, in the same cycle as the grant, latch the byte and mode, pulse o_req_ready[k], and set o_gnt[k].
REQ-022 SHALL set ptr to k+1 mod 4 at grant; ptr is 0 after reset.
REQ-023 Polling path: IDLE -> RD_SR, which issues a read of SR (o_cs=1, o_rw=1, o_addr=0), -> CHK_SR.
REQ-024 In CHK_SR, i_rdata[7]=1 -> WR_BR; otherwise -> GAP.
REQ-025 GAP SHALL hold for POLL_GAP cycles, then -> RD_SR.
REQ-026 Interrupt path: IDLE -> EN_IRQ, which writes SR=0x01, -> WAIT_IRQ.
REQ-027 WAIT_IRQ SHALL remain until i_irq_n=0 is sampled, then -> WR_BR.
REQ-028 WR_BR SHALL write the latched byte to BR (o_addr=1), increment o_cnt, and -> WR_SR.
REQ-029 WR_SR SHALL write SR = {7'b0, latched_mode} to clear the ready flag and start printing, then -> IDLE with o_gnt cleared.
REQ-030 o_cs SHALL be high for exactly one cycle in each of RD_SR, EN_IRQ, WR_BR and WR_SR, and low in all other states.
REQ-031 Best case per byte: polling 4 cycles IDLE->IDLE; interrupt 3 cycles plus WAIT_IRQ dwell.
REQ-032 A wait counter SHALL clear on grant and increment each cycle in CHK_SR, GAP and WAIT_IRQ.
REQ-033 When the wait counter reaches TIMEOUT, SHALL pulse o_err, write SR=0x00, go to IDLE, discard the byte, and leave o_cnt unchanged.
REQ-034 A change on i_mode mid-transfer SHALL be ignored; the new mode applies from the next grant.
REQ-035 A requester that drops i_req_valid after its o_req_ready pulse SHALL be unaffected; its byte is already latched.
REQ-036 New requests SHALL not be granted while o_busy=1; ready pulses occur only in IDLE.
REQ-037 i_irq_n low while in IDLE, polling states or WR_* SHALL be ignored.

Reset
REQ-038 On i_rst=1 at a clock edge, from any state, SHALL enter IDLE.
REQ-039 Reset values: ptr=0, wait counter=0, o_cnt=0, and o_req_ready, o_cs, o_rw, o_addr, o_wdata, o_gnt, o_busy, o_err all 0.
REQ-040 A transfer interrupted by reset SHALL be abandoned with no further bus strobes.

Verification
REQ-041 Polling, single request: i_req_valid=0001, data 0x5A, SR read returns 0x80 -> strobes in order: read SR; write BR=0x5A; write SR=0x00; o_cnt=1.
REQ-042 Polling, not ready: SR reads 0x00 twice, then 0x80 -> read strobes spaced POLL_GAP+2 cycles apart, then BR written.
REQ-043 Round-robin: all four requesters valid continuously -> grant order 0,1,2,3,0 and one o_req_ready pulse per grant.
REQ-044 Interrupt mode: write SR=0x01; i_irq_n held high 10 cycles then low -> write BR, then write SR=0x01; o_cnt increments.
REQ-045 Timeout: i_irq_n never asserted -> o_err pulses after TIMEOUT cycles, SR=0x00 written, back to IDLE, o_cnt unchanged.
REQ-046 Reset in WAIT_IRQ: i_rst=1 -> next cycle IDLE, o_gnt=0, o_cnt=0, no BR write.

Source files
------------

// File: rtl/poc_arbiter.sv
// poc_arbiter: round-robin arbiter that forwards one byte per transfer from
// four requesters to a parallel output controller (POC).  Each transfer
// either polls the POC status register until its ready bit is set, or arms
// the POC interrupt and waits for i_irq_n.  It then writes the byte to the
// buffer register and re-writes the status register to start printing.
//
// Ports
//   i_clk        sole clock, rising edge
//   i_rst        synchronous active-high reset
//   i_mode       0 = polling, 1 = interrupt (sampled at grant)
//   i_req_valid  per-requester byte-pending flags
//   i_req_data   packed bytes, requester k in bits [8k+7:8k]
//   o_req_ready  one-hot pulse: requester's byte captured this cycle
//   o_cs         one-cycle POC bus strobe
//   o_rw         1 = read, 0 = write (valid with o_cs)
//   o_addr       0 = status register SR, 1 = buffer register BR
//   o_wdata      write data (valid with o_cs and o_rw = 0)
//   i_rdata      POC read data, valid the cycle after a read strobe
//   i_irq_n      POC interrupt, active-low level
//   o_gnt        one-hot owner of the transfer in progress, 0 when idle
//   o_busy       high whenever a transfer is in progress
//   o_err        one-cycle pulse when a transfer is aborted on timeout
//   o_cnt        bytes delivered to BR, wraps at 16 bits
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | no transfer; grant round-robin and capture the byte
// RD_SR    | strobe a read of SR
// CHK_SR   | inspect SR ready bit (i_rdata[7])
// GAP      | idle POLL_GAP cycles before the next SR poll
// EN_IRQ   | write SR = 0x01 to enable the POC interrupt
// WAIT_IRQ | wait for i_irq_n low
// WR_BR    | write the captured byte to BR, count it
// WR_SR    | write SR = {7'b0, mode} (or 0x00 with o_err on abort)

module poc_arbiter #(
  parameter int POLL_GAP = 4,
  parameter int TIMEOUT  = 1023
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_mode,
  input  logic [3:0]  i_req_valid,
  input  logic [31:0] i_req_data,
  output logic [3:0]  o_req_ready,
  output logic        o_cs,
  output logic        o_rw,
  output logic        o_addr,
  output logic [7:0]  o_wdata,
  input  logic [7:0]  i_rdata,
  input  logic        i_irq_n,
  output logic [3:0]  o_gnt,
  output logic        o_busy,
  output logic        o_err,
  output logic [15:0] o_cnt
);

  localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam int GAP_W  = (POLL_GAP < 3) ? 1 : $clog2(POLL_GAP);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
  localparam logic [GAP_W-1:0]  GAP_LOAD  = GAP_W'(POLL_GAP - 1);

  typedef enum logic [2:0] {
    IDLE, RD_SR, CHK_SR, GAP, EN_IRQ, WAIT_IRQ, WR_BR, WR_SR
  } state_t;

  state_t             state, state_nxt;
  logic [1:0]         ptr;
  logic [7:0]         byte_q;
  logic               mode_q;
  logic               abort_q;
  logic [3:0]         gnt_q;
  logic [WAIT_W-1:0]  wait_cnt;
  logic [GAP_W-1:0]   gap_cnt;
  logic [15:0]        cnt_q;

  logic               grant_hit;
  logic [1:0]         grant_idx;
  logic               grant;
  logic               wait_last;
  logic               timeout;
  logic               unused_rdata;

  // Only the ready bit of SR is meaningful to this block.
  assign unused_rdata = ^i_rdata[6:0];

  // Round-robin search starting at ptr.
  always_comb begin
    grant_hit = 1'b0;
    grant_idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (!grant_hit && i_req_valid[ptr + 2'(i)]) begin
        grant_hit = 1'b1;
        grant_idx = ptr + 2'(i);
      end
    end
  end

  // A capture during reset would be thrown away, so no ready pulse then.
  assign grant     = (state == IDLE) && grant_hit && !i_rst;
  assign wait_last = (wait_cnt == WAIT_LAST);

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  // Ready (SR bit 7 or irq) wins over a timeout landing in the same cycle.
  // A timeout reuses WR_SR so the abort SR write is an ordinary strobe.
  always_comb begin
    state_nxt = state;
    timeout   = 1'b0;
    case (state)
      IDLE:     if (grant) state_nxt = i_mode ? EN_IRQ : RD_SR;
      RD_SR:    state_nxt = CHK_SR;
      CHK_SR: begin
        if (i_rdata[7]) begin
          state_nxt = WR_BR;
        end else if (wait_last) begin
          timeout   = 1'b1;
          state_nxt = WR_SR;
        end else begin
          state_nxt = GAP;
        end
      end
      GAP: begin
        if (wait_last) begin
          timeout   = 1'b1;
          state_nxt = WR_SR;
        end else if (gap_cnt == '0) begin
          state_nxt = RD_SR;
        end
      end
      EN_IRQ:   state_nxt = WAIT_IRQ;
      WAIT_IRQ: begin
        if (!i_irq_n) begin
          state_nxt = WR_BR;
        end else if (wait_last) begin
          timeout   = 1'b1;
          state_nxt = WR_SR;
        end
      end
      WR_BR:    state_nxt = WR_SR;
      WR_SR:    state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ptr      <= 2'd0;
      byte_q   <= 8'h00;
      mode_q   <= 1'b0;
      abort_q  <= 1'b0;
      gnt_q    <= 4'b0000;
      wait_cnt <= '0;
      gap_cnt  <= '0;
      cnt_q    <= 16'h0000;
    end else begin
      if (grant) begin
        byte_q   <= i_req_data[{grant_idx, 3'b000} +: 8];
        mode_q   <= i_mode;
        gnt_q    <= 4'b0001 << grant_idx;
        ptr      <= grant_idx + 2'd1;
        wait_cnt <= '0;
        abort_q  <= 1'b0;
      end
      if (state == CHK_SR || state == GAP || state == WAIT_IRQ)
        wait_cnt <= wait_cnt + 1'b1;
      if (state == CHK_SR)
        gap_cnt <= GAP_LOAD;
      else if (state == GAP && gap_cnt != '0)
        gap_cnt <= gap_cnt - 1'b1;
      if (timeout)
        abort_q <= 1'b1;
      if (state == WR_BR)
        cnt_q <= cnt_q + 16'd1;
      if (state == WR_SR)
        gnt_q <= 4'b0000;
    end
  end

  always_comb begin
    o_req_ready = grant ? (4'b0001 << grant_idx) : 4'b0000;
    o_cs        = 1'b0;
    o_rw        = 1'b0;
    o_addr      = 1'b0;
    o_wdata     = 8'h00;
    o_err       = 1'b0;
    o_busy      = (state != IDLE);
    o_gnt       = gnt_q;
    o_cnt       = cnt_q;
    case (state)
      RD_SR: begin
        o_cs = 1'b1;
        o_rw = 1'b1;
      end
      EN_IRQ: begin
        o_cs    = 1'b1;
        o_wdata = 8'h01;
      end
      WR_BR: begin
        o_cs    = 1'b1;
        o_addr  = 1'b1;
        o_wdata = byte_q;
      end
      WR_SR: begin
        o_cs    = 1'b1;
        o_wdata = abort_q ? 8'h00 : {7'b0, mode_q};
        o_err   = abort_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_poc_arbiter.sv
module tb_poc_arbiter;

  localparam int POLL_GAP = 4;
  localparam int TIMEOUT  = 50;

  localparam int OP_NONE = 0, OP_READ = 1, OP_CHECK = 2, OP_GAP = 3;
  localparam int OP_ARM = 4, OP_WAIT = 5, OP_DATA = 6, OP_STATUS = 7;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_mode = 1'b0;
  logic [3:0]  i_req_valid = 4'b0;
  logic [31:0] i_req_data = 32'h0;
  logic [7:0]  i_rdata = 8'h0;
  logic        i_irq_n = 1'b1;
  logic [3:0]  o_req_ready;
  logic        o_cs, o_rw, o_addr;
  logic [7:0]  o_wdata;
  logic [3:0]  o_gnt;
  logic        o_busy, o_err;
  logic [15:0] o_cnt;

  poc_arbiter #(.POLL_GAP(POLL_GAP), .TIMEOUT(TIMEOUT)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_mode(i_mode),
    .i_req_valid(i_req_valid), .i_req_data(i_req_data),
    .o_req_ready(o_req_ready), .o_cs(o_cs), .o_rw(o_rw), .o_addr(o_addr),
    .o_wdata(o_wdata), .i_rdata(i_rdata), .i_irq_n(i_irq_n),
    .o_gnt(o_gnt), .o_busy(o_busy), .o_err(o_err), .o_cnt(o_cnt)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, got, exp);
    end
  endtask

  // Observation logs filled from DUT outputs, checked against literals.
  typedef struct { int cyc; logic rw; logic addr; logic [7:0] wdata; } strobe_t;
  typedef struct { int cyc; int idx; } grant_t;
  strobe_t slog[$];
  grant_t  glog[$];
  int      elog[$];
  int      busy_cycles = 0;
  bit      rd_seen = 1'b0;

  // Behavioural model: a transfer is described by its age m_t (1 = first
  // busy cycle), the scheduled BR/SR write cycles and the waiting budget.
  bit          armed = 1'b0;
  bit          m_busy = 1'b0;
  int          m_owner = 0;
  bit          m_mode = 1'b0;
  logic [7:0]  m_byte = 8'h0;
  int          m_t = 0;
  int          m_waited = 0;
  int          m_wr_at = -1;
  int          m_sr_at = -1;
  bit          m_abort = 1'b0;
  int          m_ptr = 0;
  logic [15:0] m_cnt = 16'h0;

  function automatic int rr_pick(input logic [3:0] v, input int p);
    for (int i = 0; i < 4; i++)
      if (v[(p + i) % 4]) return (p + i) % 4;
    return -1;
  endfunction

  function automatic int cur_op();
    if (!m_busy) return OP_NONE;
    if (m_t == m_sr_at) return OP_STATUS;
    if (m_t == m_wr_at) return OP_DATA;
    if (!m_mode) begin
      case ((m_t - 1) % (POLL_GAP + 2))
        0:       return OP_READ;
        1:       return OP_CHECK;
        default: return OP_GAP;
      endcase
    end
    return (m_t == 1) ? OP_ARM : OP_WAIT;
  endfunction

  task automatic wait_tick();
    m_waited++;
    if (m_waited == TIMEOUT) begin
      m_abort = 1'b1;
      m_sr_at = m_t + 1;
    end
  endtask

  always @(negedge i_clk) begin : cmp
    int op;
    int k;
    logic [3:0] e_ready;
    logic e_cs, e_rw, e_addr, e_err;
    logic [7:0] e_wdata;
    cyc++;
    op = cur_op();
    k = (!m_busy && !i_rst) ? rr_pick(i_req_valid, m_ptr) : -1;
    e_ready = (k >= 0) ? 4'(1 << k) : 4'b0;
    e_cs = 1'b0; e_rw = 1'b0; e_addr = 1'b0; e_err = 1'b0; e_wdata = 8'h00;
    case (op)
      OP_READ:   begin e_cs = 1'b1; e_rw = 1'b1; end
      OP_ARM:    begin e_cs = 1'b1; e_wdata = 8'h01; end
      OP_DATA:   begin e_cs = 1'b1; e_addr = 1'b1; e_wdata = m_byte; end
      OP_STATUS: begin e_cs = 1'b1; e_wdata = m_abort ? 8'h00 : {7'b0, m_mode}; e_err = m_abort; end
      default: ;
    endcase
    if (armed) begin
      check("req_ready", o_req_ready, e_ready);
      check("busy", o_busy, m_busy);
      check("gnt", o_gnt, m_busy ? 4'(1 << m_owner) : 4'b0);
      check("cs", o_cs, e_cs);
      if (e_cs) begin
        check("rw_addr", {o_rw, o_addr}, {e_rw, e_addr});
        if (!e_rw) check("wdata", o_wdata, e_wdata);
      end
      check("err", o_err, e_err);
      check("cnt", o_cnt, m_cnt);
      if (o_cs) slog.push_back('{cyc, o_rw, o_addr, o_wdata});
      for (int i = 0; i < 4; i++)
        if (o_req_ready[i]) glog.push_back('{cyc, i});
      if (o_err) elog.push_back(cyc);
      if (o_busy) busy_cycles++;
    end
    rd_seen = o_cs && o_rw;

    if (i_rst) begin
      m_busy = 1'b0; m_ptr = 0; m_cnt = 16'h0; armed = 1'b1;
    end else if (m_busy) begin
      case (op)
        OP_CHECK: if (i_rdata[7]) begin m_wr_at = m_t + 1; m_sr_at = m_t + 2; end else wait_tick();
        OP_GAP:   wait_tick();
        OP_WAIT:  if (!i_irq_n) begin m_wr_at = m_t + 1; m_sr_at = m_t + 2; end else wait_tick();
        OP_DATA:  m_cnt = m_cnt + 16'd1;
        OP_STATUS: m_busy = 1'b0;
        default: ;
      endcase
      m_t++;
    end else if (k >= 0) begin
      m_busy = 1'b1; m_owner = k; m_ptr = (k + 1) % 4; m_mode = i_mode;
      m_byte = i_req_data[8*k +: 8]; m_t = 1; m_waited = 0;
      m_wr_at = -1; m_sr_at = -1; m_abort = 1'b0;
    end
  end

  // Stimulus side.
  logic [7:0] sr_script[$];
  int sr_ready_pct = 100;
  int irq_pct = 0;

  function automatic logic [7:0] rand_sr();
    logic [6:0] low;
    low = 7'($urandom);
    return {($urandom_range(99) < sr_ready_pct), low};
  endfunction

  task automatic step();
    @(posedge i_clk);
    #1;
    if (rd_seen && sr_script.size() > 0) i_rdata = sr_script.pop_front();
    else if (rd_seen) i_rdata = rand_sr();
    else i_rdata = 8'($urandom);
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
  endtask

  task automatic check_strobe(input string name, input int idx, input logic rw,
                              input logic addr, input logic [7:0] wd);
    if (idx >= slog.size()) begin
      check({name, "_present"}, 0, 1);
    end else begin
      check(name, {slog[idx].rw, slog[idx].addr}, {rw, addr});
      if (!rw) check({name, "_data"}, slog[idx].wdata, wd);
    end
  endtask

  initial begin
    int base, gbase, ebase, bbase, n;

    // Reset state.
    step();
    i_rst = 1'b0;
    check("reset_outputs", {o_req_ready, o_cs, o_rw, o_addr, o_wdata, o_gnt, o_busy, o_err}, 0);
    check("reset_cnt", o_cnt, 16'h0);

    // Polling, single request, ready at first poll.
    do_reset();
    base = slog.size(); bbase = busy_cycles;
    sr_ready_pct = 100;
    sr_script = '{8'h80};
    i_mode = 1'b0; i_req_data = 32'h0000005A; i_req_valid = 4'b0001;
    step();
    i_req_valid = 4'b0000;
    repeat (10) step();
    check("poll1_strobes", slog.size() - base, 3);
    check_strobe("poll1_rd_sr", base, 1'b1, 1'b0, 8'h00);
    check_strobe("poll1_wr_br", base + 1, 1'b0, 1'b1, 8'h5A);
    check_strobe("poll1_wr_sr", base + 2, 1'b0, 1'b0, 8'h00);
    check("poll1_cnt", o_cnt, 16'd1);
    check("poll1_busy_cycles", busy_cycles - bbase, 4);

    // Polling, not ready twice.
    do_reset();
    base = slog.size();
    sr_script = '{8'h00, 8'h00, 8'h80};
    i_req_data = 32'h00000033; i_req_valid = 4'b0001;
    step();
    i_req_valid = 4'b0000;
    repeat (25) step();
    check("poll3_strobes", slog.size() - base, 5);
    check_strobe("poll3_rd0", base, 1'b1, 1'b0, 8'h00);
    check_strobe("poll3_rd1", base + 1, 1'b1, 1'b0, 8'h00);
    check_strobe("poll3_rd2", base + 2, 1'b1, 1'b0, 8'h00);
    check_strobe("poll3_wr_br", base + 3, 1'b0, 1'b1, 8'h33);
    check_strobe("poll3_wr_sr", base + 4, 1'b0, 1'b0, 8'h00);
    if (slog.size() - base >= 3) begin
      check("poll3_gap01", slog[base + 1].cyc - slog[base].cyc, POLL_GAP + 2);
      check("poll3_gap12", slog[base + 2].cyc - slog[base + 1].cyc, POLL_GAP + 2);
    end
    check("poll3_cnt", o_cnt, 16'd1);

    // Round-robin with all requesters pending.
    do_reset();
    gbase = glog.size();
    i_req_data = $urandom; i_req_valid = 4'hF;
    n = 0;
    while (glog.size() - gbase < 5 && n < 60) begin step(); n++; end
    i_req_valid = 4'h0;
    repeat (6) step();
    check("rr_grants", glog.size() - gbase, 5);
    if (glog.size() - gbase >= 5) begin
      check("rr_order0", glog[gbase].idx, 0);
      check("rr_order1", glog[gbase + 1].idx, 1);
      check("rr_order2", glog[gbase + 2].idx, 2);
      check("rr_order3", glog[gbase + 3].idx, 3);
      check("rr_order4", glog[gbase + 4].idx, 0);
      for (int i = 1; i < 5; i++)
        check("rr_spacing", glog[gbase + i].cyc - glog[gbase + i - 1].cyc, 5);
    end

    // Interrupt mode, mode toggled mid-transfer.
    do_reset();
    base = slog.size();
    i_mode = 1'b1; i_irq_n = 1'b1;
    i_req_data = 32'h0000C300; i_req_valid = 4'b0010;
    step();
    i_req_valid = 4'b0000; i_mode = 1'b0;
    repeat (10) step();
    i_irq_n = 1'b0;
    step();
    i_irq_n = 1'b1;
    repeat (6) step();
    check("irq_strobes", slog.size() - base, 3);
    check_strobe("irq_en", base, 1'b0, 1'b0, 8'h01);
    check_strobe("irq_wr_br", base + 1, 1'b0, 1'b1, 8'hC3);
    check_strobe("irq_wr_sr", base + 2, 1'b0, 1'b0, 8'h01);
    check("irq_cnt", o_cnt, 16'd1);

    // Timeout with interrupt never arriving.
    do_reset();
    base = slog.size(); gbase = glog.size(); ebase = elog.size();
    i_mode = 1'b1; i_irq_n = 1'b1;
    i_req_data = 32'h00000077; i_req_valid = 4'b0001;
    step();
    i_req_valid = 4'b0000;
    repeat (TIMEOUT + 8) step();
    check("to_err_pulses", elog.size() - ebase, 1);
    check("to_strobes", slog.size() - base, 2);
    check_strobe("to_en", base, 1'b0, 1'b0, 8'h01);
    check_strobe("to_wr_sr", base + 1, 1'b0, 1'b0, 8'h00);
    if (elog.size() > ebase && glog.size() > gbase)
      check("to_latency", elog[ebase] - glog[gbase].cyc, TIMEOUT + 2);
    if (elog.size() > ebase && slog.size() - base >= 2)
      check("to_err_with_sr", slog[base + 1].cyc, elog[ebase]);
    check("to_cnt", o_cnt, 16'd0);
    check("to_idle", o_busy, 1'b0);

    // Reset while waiting for the interrupt.
    do_reset();
    i_mode = 1'b0; i_req_data = 32'h00000011; i_req_valid = 4'b0001;
    step();
    i_req_valid = 4'b0000;
    repeat (6) step();
    check("rst_pre_cnt", o_cnt, 16'd1);
    base = slog.size();
    i_mode = 1'b1; i_irq_n = 1'b1; i_req_valid = 4'b0001;
    step();
    i_req_valid = 4'b0000;
    repeat (4) step();
    i_rst = 1'b1;
    i_irq_n = 1'b0;
    step();
    i_rst = 1'b0;
    check("rst_busy", o_busy, 1'b0);
    check("rst_gnt", o_gnt, 4'b0);
    check("rst_cnt", o_cnt, 16'd0);
    repeat (5) step();
    i_irq_n = 1'b1;
    check("rst_no_br", slog.size() - base, 1);

    // Randomised traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      if (i % 200 == 0) begin
        case ($urandom_range(2))
          0:       irq_pct = 0;
          1:       irq_pct = 4;
          default: irq_pct = 25;
        endcase
        sr_ready_pct = $urandom_range(60, 10);
      end
      i_req_valid = 4'($urandom) & 4'($urandom);
      i_req_data = $urandom;
      if ($urandom_range(7) == 0) i_mode = ~i_mode;
      i_irq_n = ($urandom_range(99) < irq_pct) ? 1'b0 : 1'b1;
      i_rst = ($urandom_range(399) == 0);
      step();
    end
    i_rst = 1'b0;
    i_req_valid = 4'b0;
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
